// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, one-entry skid buffer for ID stalls,
// branch redirect with discard of the in-flight response.
//   state | meaning
//   IDLE  | one cycle after reset before the first fetch
//   REQ   | imem_req high, waiting for imem_ack
//   STALL | word parked in skid buffer, waiting for freeze to drop
module if_fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        Br_taken,
  input  logic [31:0] Br_Addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] PC,
  output logic        inst_valid
);

  typedef enum logic [1:0] {IDLE, REQ, STALL} state_t;

  state_t      state, state_nx;
  logic [31:0] fetch_pc, fetch_pc_nx;
  logic [31:0] skid_word, skid_word_nx;
  logic [31:0] skid_addr, skid_addr_nx;
  logic        skid_valid, skid_valid_nx;
  logic        discard, discard_nx;
  logic [31:0] hold_addr, hold_addr_nx;
  logic [31:0] instr_nx, pc_nx;
  logic        valid_nx;
  logic        ack_acc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      fetch_pc    <= '0;
      skid_word   <= '0;
      skid_addr   <= '0;
      skid_valid  <= 1'b0;
      discard     <= 1'b0;
      hold_addr   <= '0;
      Instruction <= '0;
      PC          <= '0;
      inst_valid  <= 1'b0;
    end else begin
      state       <= state_nx;
      fetch_pc    <= fetch_pc_nx;
      skid_word   <= skid_word_nx;
      skid_addr   <= skid_addr_nx;
      skid_valid  <= skid_valid_nx;
      discard     <= discard_nx;
      hold_addr   <= hold_addr_nx;
      Instruction <= instr_nx;
      PC          <= pc_nx;
      inst_valid  <= valid_nx;
    end
  end

  // While discarding, the abandoned request keeps its address until its ack arrives.
  assign imem_req  = (state == REQ);
  assign imem_addr = discard ? hold_addr : fetch_pc;
  assign ack_acc   = (state == REQ) && imem_ack;

  always_comb begin
    state_nx      = state;
    fetch_pc_nx   = fetch_pc;
    skid_word_nx  = skid_word;
    skid_addr_nx  = skid_addr;
    skid_valid_nx = skid_valid;
    discard_nx    = discard;
    hold_addr_nx  = hold_addr;
    instr_nx      = Instruction;
    pc_nx         = PC;
    valid_nx      = inst_valid;

    if (Br_taken) begin
      discard_nx    = (state == REQ) && !imem_ack;
      hold_addr_nx  = imem_addr;
      fetch_pc_nx   = Br_Addr & 32'hFFFF_FFFC;
      skid_valid_nx = 1'b0;
      instr_nx      = '0;
      pc_nx         = '0;
      valid_nx      = 1'b0;
      state_nx      = REQ;
    end else begin
      unique case (state)
        IDLE:    state_nx = REQ;
        REQ:     if (ack_acc && !discard && freeze) state_nx = STALL;
        STALL:   if (!freeze) state_nx = REQ;
        default: state_nx = IDLE;
      endcase

      if (ack_acc && discard) begin
        discard_nx = 1'b0;
        if (!freeze) begin
          instr_nx = '0;
          pc_nx    = '0;
          valid_nx = 1'b0;
        end
      end else if (ack_acc) begin
        fetch_pc_nx = fetch_pc + 32'd4;
        if (freeze) begin
          skid_word_nx  = imem_rdata;
          skid_addr_nx  = imem_addr;
          skid_valid_nx = 1'b1;
        end else begin
          instr_nx = imem_rdata;
          pc_nx    = imem_addr + 32'd4;
          valid_nx = 1'b1;
        end
      end else if (!freeze) begin
        skid_valid_nx = 1'b0;
        instr_nx      = skid_valid ? skid_word : '0;
        pc_nx         = skid_valid ? skid_addr + 32'd4 : '0;
        valid_nx      = skid_valid;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed vector table for the fetch unit, then randomized traffic against a queue-based model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, freeze, Br_taken, imem_ack;
  logic [31:0] Br_Addr, imem_rdata;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, Instruction, PC;

  int checks = 0;
  int errors = 0;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze), .Br_taken(Br_taken), .Br_Addr(Br_Addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .Instruction(Instruction), .PC(PC), .inst_valid(inst_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          rst, frz, br, ack;
    logic [31:0] baddr, rdata;
    bit          e_req;
    logic [31:0] e_addr, e_ins, e_pc;
    bit          e_v;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit f, bit b, logic [31:0] ba, bit a, logic [31:0] rd,
                              bit er, logic [31:0] ea, logic [31:0] ei, logic [31:0] ep, bit ev);
    vec_t v;
    v.rst = r; v.frz = f; v.br = b; v.baddr = ba; v.ack = a; v.rdata = rd;
    v.e_req = er; v.e_addr = ea; v.e_ins = ei; v.e_pc = ep; v.e_v = ev;
    return v;
  endfunction

  // Reference model: fetch pointer plus a queue for the skid entry.
  typedef struct { logic [31:0] word, addr; } ent_t;
  ent_t        skid_q[$];
  int          phase;  // 0 post-reset wait, 1 request issued, 2 parked on freeze
  bit          m_drop;
  logic [31:0] m_drop_addr, m_pc, o_ins, o_pc;
  bit          o_v;

  task automatic model_reset();
    skid_q.delete();
    phase = 0; m_drop = 0; m_drop_addr = 0; m_pc = 0;
    o_ins = 0; o_pc = 0; o_v = 0;
  endtask

  task automatic model_step(bit r, bit f, bit b, logic [31:0] ba, bit a, logic [31:0] rd);
    bit          got;
    logic [31:0] cur;
    ent_t        e;
    if (!r) begin
      model_reset();
      return;
    end
    got = (phase == 1) && a;
    cur = m_drop ? m_drop_addr : m_pc;
    if (b) begin
      if (phase == 1 && !a) begin
        m_drop_addr = cur;
        m_drop = 1;
      end else m_drop = 0;
      m_pc = {ba[31:2], 2'b00};
      skid_q.delete();
      o_ins = 0; o_pc = 0; o_v = 0;
      phase = 1;
      return;
    end
    if (got && m_drop) begin
      m_drop = 0;
      if (!f) begin o_ins = 0; o_pc = 0; o_v = 0; end
      return;
    end
    if (got) begin
      m_pc = m_pc + 4;
      if (f) begin
        skid_q.push_back('{rd, cur});
        phase = 2;
      end else begin
        o_ins = rd; o_pc = cur + 4; o_v = 1;
      end
      return;
    end
    if (!f) begin
      if (skid_q.size() > 0) begin
        e = skid_q.pop_front();
        o_ins = e.word; o_pc = e.addr + 4; o_v = 1;
      end else begin
        o_ins = 0; o_pc = 0; o_v = 0;
      end
    end
    if (phase == 0 || (phase == 2 && !f)) phase = 1;
  endtask

  initial begin
    bit          pend;
    int          lat;
    logic [31:0] paddr;

    vecs.push_back(mk(1,0,0,0,           0,0,                       0,32'h0,0,0,0));
    vecs.push_back(mk(1,0,0,0,           1,mem_word(0),             1,32'h0,0,0,0));
    vecs.push_back(mk(1,0,0,0,           1,mem_word(4),             1,32'h4,mem_word(0),4,1));
    vecs.push_back(mk(1,0,0,0,           1,mem_word(8),             1,32'h8,mem_word(4),8,1));
    vecs.push_back(mk(1,1,0,0,           1,mem_word(12),            1,32'hC,mem_word(8),12,1));
    vecs.push_back(mk(1,1,0,0,           1,32'hDEAD_BEEF,           0,32'h10,mem_word(8),12,1));
    vecs.push_back(mk(1,0,0,0,           0,0,                       0,32'h10,mem_word(8),12,1));
    vecs.push_back(mk(1,0,0,0,           0,0,                       1,32'h10,mem_word(12),16,1));
    vecs.push_back(mk(1,0,1,32'h103,     0,0,                       1,32'h10,0,0,0));
    vecs.push_back(mk(1,0,0,0,           0,0,                       1,32'h10,0,0,0));
    vecs.push_back(mk(1,0,0,0,           1,mem_word(16),            1,32'h10,0,0,0));
    vecs.push_back(mk(1,0,0,0,           1,mem_word(32'h100),       1,32'h100,0,0,0));
    vecs.push_back(mk(1,0,1,32'hFFFF_FFFF,1,mem_word(32'h104),      1,32'h104,mem_word(32'h100),32'h104,1));
    vecs.push_back(mk(1,0,0,0,           1,mem_word(32'hFFFF_FFFC), 1,32'hFFFF_FFFC,0,0,0));
    vecs.push_back(mk(0,0,0,0,           0,0,                       1,32'h0,mem_word(32'hFFFF_FFFC),0,1));
    vecs.push_back(mk(1,0,0,0,           0,0,                       0,32'h0,0,0,0));
    vecs.push_back(mk(1,1,0,0,           1,mem_word(0),             1,32'h0,0,0,0));
    vecs.push_back(mk(1,1,1,32'h40,      0,0,                       0,32'h4,0,0,0));
    vecs.push_back(mk(1,0,0,0,           0,0,                       1,32'h40,0,0,0));
    vecs.push_back(mk(1,0,0,0,           1,mem_word(32'h40),        1,32'h40,0,0,0));
    vecs.push_back(mk(1,0,0,0,           0,0,                       1,32'h44,mem_word(32'h40),32'h44,1));

    rst = 0; freeze = 0; Br_taken = 0; Br_Addr = 0; imem_ack = 0; imem_rdata = 0;
    @(posedge clk); #1;
    foreach (vecs[i]) begin
      chk($sformatf("vec%0d imem_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
      chk($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d Instruction", i), Instruction, vecs[i].e_ins);
      chk($sformatf("vec%0d PC", i), PC, vecs[i].e_pc);
      chk($sformatf("vec%0d inst_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].e_v});
      rst = vecs[i].rst; freeze = vecs[i].frz; Br_taken = vecs[i].br; Br_Addr = vecs[i].baddr;
      imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
      @(posedge clk); #1;
    end

    rst = 0; freeze = 0; Br_taken = 0; imem_ack = 0;
    @(posedge clk); #1;
    model_reset();
    pend = 0; lat = 0; paddr = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      chk($sformatf("rnd%0d imem_req", cyc), {31'd0, imem_req}, {31'd0, phase == 1});
      chk($sformatf("rnd%0d imem_addr", cyc), imem_addr, m_drop ? m_drop_addr : m_pc);
      chk($sformatf("rnd%0d Instruction", cyc), Instruction, o_ins);
      chk($sformatf("rnd%0d PC", cyc), PC, o_pc);
      chk($sformatf("rnd%0d inst_valid", cyc), {31'd0, inst_valid}, {31'd0, o_v});

      rst      = ($urandom_range(0, 79) != 0);
      freeze   = ($urandom_range(0, 3) == 0);
      Br_taken = ($urandom_range(0, 9) == 0);
      Br_Addr  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
      imem_ack = 0;
      imem_rdata = $urandom;
      if (imem_req) begin
        if (!pend) begin
          pend  = 1;
          paddr = imem_addr;
          lat   = $urandom_range(0, 3);
        end else begin
          chk($sformatf("rnd%0d addr_stable", cyc), imem_addr, paddr);
        end
        if (lat == 0) begin
          imem_ack   = 1;
          imem_rdata = mem_word(paddr);
          pend       = 0;
        end else lat--;
      end else if ($urandom_range(0, 4) == 0) begin
        imem_ack = 1;
      end
      if (!rst) pend = 0;
      model_step(rst, freeze, Br_taken, Br_Addr, imem_ack, imem_rdata);
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
